ulpb_layer_tx_agent: RTL

- Synthesizable layer-side initiator for the TX interface of a ulpb_node32: buffers one multi-word message from local logic and drives TX_ADDR/TX_DATA/TX_REQ/TX_PEND/PRIORITY word by word using four-phase handshakes.
- Collects the TX_SUCC/TX_FAIL response, returns TX_RESP_ACK and retries failed messages.
- Sits between a layer's register or DMA logic and the node. It replaces the behavioural TX driver and response acker used in node-level simulation.

---
 rtl/ulpb_layer_tx_agent_pkg.sv | 27 ++
 rtl/ulpb_layer_tx_agent_sync2.sv | 24 ++
 rtl/ulpb_layer_tx_agent.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ulpb_layer_tx_agent_pkg.sv
// Shared definitions for the ulpb layer TX agent: bus widths, FSM states,
// attempt result codes and a counter-width helper.
package ulpb_layer_tx_agent_pkg;

  localparam int ULPB_ADDR_WIDTH = 8;
  localparam int ULPB_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_REL,
    ST_RESP,
    ST_RACK,
    ST_FIN
  } state_e;

  typedef enum logic {
    RES_OK   = 1'b0,
    RES_FAIL = 1'b1
  } result_e;

  // Bits needed to hold 0..maxval, never less than one.
  function automatic int ulpb_cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/ulpb_layer_tx_agent_sync2.sv
// Two-flop synchronizer for a single-bit level crossing into the layer clock.
module ulpb_sync2 (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ulpb_layer_tx_agent.sv
// Layer-side TX initiator for a ulpb_node32: buffers one message, sends it word
// by word with four-phase handshakes, acknowledges the response and retries.
module ulpb_layer_tx_agent
  import ulpb_layer_tx_agent_pkg::*;
#(
  parameter int ADDR_WIDTH   = ULPB_ADDR_WIDTH,
  parameter int DATA_WIDTH   = ULPB_DATA_WIDTH,
  parameter int DEPTH        = 4,
  parameter int MAX_RETRY    = 3,
  parameter int RESP_TIMEOUT = 1024
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic [ADDR_WIDTH-1:0]                i_msg_addr,
  input  logic [DATA_WIDTH-1:0]                i_msg_data,
  input  logic                                 i_msg_wr,
  input  logic                                 i_msg_last,
  input  logic                                 i_msg_priority,
  output logic                                 o_msg_busy,
  output logic                                 o_msg_ovf,
  output logic                                 o_msg_done,
  output logic                                 o_msg_fail,
  output logic [ulpb_cnt_width(MAX_RETRY)-1:0] o_retry_cnt,
  output logic [ADDR_WIDTH-1:0]                o_tx_addr,
  output logic [DATA_WIDTH-1:0]                o_tx_data,
  output logic                                 o_tx_req,
  output logic                                 o_tx_pend,
  output logic                                 o_priority,
  input  logic                                 i_tx_ack,
  input  logic                                 i_tx_succ,
  input  logic                                 i_tx_fail,
  output logic                                 o_tx_resp_ack
);

  localparam int PW = $clog2(DEPTH);
  localparam int RW = ulpb_cnt_width(MAX_RETRY);
  localparam int TW = ulpb_cnt_width(RESP_TIMEOUT - 1);

  logic [DATA_WIDTH-1:0] r_buf [DEPTH];
  logic [PW:0]           r_wptr;
  logic [PW-1:0]         r_last_idx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_prio;
  logic                  r_ovf;

  state_e                r_state, w_state_next;
  logic [PW-1:0]         r_rptr, w_rptr_next;
  logic [RW-1:0]         r_attempt, w_attempt_next;
  result_e               r_result, w_result_next;
  logic [TW-1:0]         r_tmo, w_tmo_next;
  logic                  w_decide;

  logic r_busy, r_tx_req, r_resp_ack, r_done;
  logic w_ack_s, w_succ_s, w_fail_s;
  logic w_full, w_store, w_drop, w_launch;

  ulpb_sync2 u_sync_ack  (.i_clk(i_clk), .i_reset(i_reset), .i_d(i_tx_ack),  .o_q(w_ack_s));
  ulpb_sync2 u_sync_succ (.i_clk(i_clk), .i_reset(i_reset), .i_d(i_tx_succ), .o_q(w_succ_s));
  ulpb_sync2 u_sync_fail (.i_clk(i_clk), .i_reset(i_reset), .i_d(i_tx_fail), .o_q(w_fail_s));

  // A LAST push into a full buffer still launches the DEPTH buffered words; only its own word is lost.
  assign w_full   = (r_wptr == (PW+1)'(DEPTH));
  assign w_store  = i_msg_wr && !r_busy && !w_full;
  assign w_drop   = i_msg_wr && (r_busy || w_full);
  assign w_launch = i_msg_wr && i_msg_last && !r_busy;

  always_ff @(posedge i_clk) begin
    if (w_store) begin
      r_buf[r_wptr[PW-1:0]] <= i_msg_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr     <= '0;
      r_last_idx <= '0;
      r_addr     <= '0;
      r_prio     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_store && r_wptr == '0) begin
        r_addr <= i_msg_addr;
        r_prio <= i_msg_priority;
      end
      if (w_launch) begin
        r_wptr     <= '0;
        r_last_idx <= w_full ? PW'(DEPTH - 1) : r_wptr[PW-1:0];
      end else if (w_store) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_launch) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_rptr_next    = r_rptr;
    w_attempt_next = r_attempt;
    w_result_next  = r_result;
    w_tmo_next     = r_tmo;
    w_decide       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          w_rptr_next    = '0;
          w_attempt_next = '0;
          w_result_next  = RES_OK;
          w_state_next   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (w_ack_s) w_state_next = ST_REL;
      end
      ST_REL: begin
        if (!w_ack_s) begin
          if (r_rptr != r_last_idx) begin
            w_rptr_next  = r_rptr + 1'b1;
            w_state_next = ST_REQ;
          end else begin
            w_tmo_next   = '0;
            w_state_next = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (w_fail_s) begin
          w_result_next = RES_FAIL;
          w_state_next  = ST_RACK;
        end else if (w_succ_s) begin
          w_result_next = RES_OK;
          w_state_next  = ST_RACK;
        end else if (r_tmo == TW'(RESP_TIMEOUT - 1)) begin
          w_result_next = RES_FAIL;
          w_decide      = 1'b1;
        end else begin
          w_tmo_next = r_tmo + 1'b1;
        end
      end
      ST_RACK: begin
        if (!w_succ_s && !w_fail_s) w_decide = 1'b1;
      end
      ST_FIN: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    // Retry replays the untouched buffer from word 0; ack_s is already low here.
    if (w_decide) begin
      if (w_result_next == RES_FAIL && int'(r_attempt) < MAX_RETRY) begin
        w_attempt_next = r_attempt + 1'b1;
        w_rptr_next    = '0;
        w_state_next   = ST_REQ;
      end else begin
        w_state_next = ST_FIN;
      end
    end
  end

  // Handshake outputs are registered from the next state so the node never sees decode glitches.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_rptr     <= '0;
      r_attempt  <= '0;
      r_result   <= RES_OK;
      r_tmo      <= '0;
      r_busy     <= 1'b0;
      r_tx_req   <= 1'b0;
      r_resp_ack <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rptr     <= w_rptr_next;
      r_attempt  <= w_attempt_next;
      r_result   <= w_result_next;
      r_tmo      <= w_tmo_next;
      r_busy     <= (w_state_next != ST_IDLE);
      r_tx_req   <= (w_state_next == ST_REQ);
      r_resp_ack <= (w_state_next == ST_RACK);
      r_done     <= (w_state_next == ST_FIN);
    end
  end

  assign o_msg_busy    = r_busy;
  assign o_msg_ovf     = r_ovf;
  assign o_msg_done    = r_done;
  assign o_msg_fail    = r_done && (r_result == RES_FAIL);
  assign o_retry_cnt   = r_done ? r_attempt : '0;
  assign o_tx_req      = r_tx_req;
  assign o_tx_resp_ack = r_resp_ack;
  assign o_tx_addr     = r_tx_req ? r_addr : '0;
  assign o_tx_data     = r_tx_req ? r_buf[r_rptr] : '0;
  assign o_tx_pend     = r_tx_req && (r_rptr != r_last_idx);
  assign o_priority    = r_tx_req && r_prio;

endmodule
